// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW writeback path.
// Slot enum values double as indices into per-slot arrays.
package vliw_pkg;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int NUM_REGS  = 1 << REG_AW;
  localparam int CNT_W     = 16;
  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    SLOT_LSU    = 2'd0,
    SLOT_IXU1   = 2'd1,
    SLOT_IXU2   = 2'd2,
    SLOT_BRANCH = 2'd3
  } slot_e;

  // Highest priority first; used to break same-destination collisions.
  localparam slot_e PRIO_ORDER [NUM_SLOTS] = '{SLOT_BRANCH, SLOT_IXU2, SLOT_IXU1, SLOT_LSU};

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  function automatic logic outranks(slot_e a, slot_e b);
    logic found;
    logic result;
    found  = 1'b0;
    result = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found && PRIO_ORDER[i] == a) begin
        found  = 1'b1;
        result = (a != b);
      end else if (!found && PRIO_ORDER[i] == b) begin
        found  = 1'b1;
        result = 1'b0;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_slot_buffer.sv
// One-entry result buffer for a single writeback slot.
// An x0 result still occupies the entry for one cycle, then frees itself.
module wb_slot_buffer
  import vliw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  input  logic [REG_AW-1:0] res_rd,
  input  logic [XLEN-1:0]   res_data,
  output logic              res_ready,
  input  logic              commit,
  output wb_entry_t         entry
);

  logic retire;
  logic accept;

  assign retire    = commit || (entry.valid && (entry.rd == '0));
  assign res_ready = !entry.valid || retire;
  assign accept    = res_valid && res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
    end else if (accept) begin
      entry.valid <= 1'b1;
      entry.rd    <= res_rd;
      entry.data  <= res_data;
    end else if (retire) begin
      entry.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Final VLIW pipeline stage: buffers one result per slot, arbitrates
// same-destination collisions, drives RF write ports and the pending-write scoreboard.
module writeback_stage
  import vliw_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,

  input  logic                lsu_res_valid,
  input  logic [REG_AW-1:0]   lsu_res_rd,
  input  logic [XLEN-1:0]     lsu_res_data,
  output logic                lsu_res_ready,
  output logic                lsu_wr_en,
  output logic [REG_AW-1:0]   lsu_rd,
  output logic [XLEN-1:0]     lsu_wr_data,
  input  logic                lsu_iss_en,
  input  logic [REG_AW-1:0]   lsu_iss_rd,

  input  logic                ixu1_res_valid,
  input  logic [REG_AW-1:0]   ixu1_res_rd,
  input  logic [XLEN-1:0]     ixu1_res_data,
  output logic                ixu1_res_ready,
  output logic                ixu1_wr_en,
  output logic [REG_AW-1:0]   ixu1_rd,
  output logic [XLEN-1:0]     ixu1_wr_data,
  input  logic                ixu1_iss_en,
  input  logic [REG_AW-1:0]   ixu1_iss_rd,

  input  logic                ixu2_res_valid,
  input  logic [REG_AW-1:0]   ixu2_res_rd,
  input  logic [XLEN-1:0]     ixu2_res_data,
  output logic                ixu2_res_ready,
  output logic                ixu2_wr_en,
  output logic [REG_AW-1:0]   ixu2_rd,
  output logic [XLEN-1:0]     ixu2_wr_data,
  input  logic                ixu2_iss_en,
  input  logic [REG_AW-1:0]   ixu2_iss_rd,

  input  logic                branch_res_valid,
  input  logic [REG_AW-1:0]   branch_res_rd,
  input  logic [XLEN-1:0]     branch_res_data,
  output logic                branch_res_ready,
  output logic                branch_wr_en,
  output logic [REG_AW-1:0]   branch_rd,
  output logic [XLEN-1:0]     branch_wr_data,
  input  logic                branch_iss_en,
  input  logic [REG_AW-1:0]   branch_iss_rd,

  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    collision_cnt
);

  logic              res_valid [NUM_SLOTS];
  logic [REG_AW-1:0] res_rd    [NUM_SLOTS];
  logic [XLEN-1:0]   res_data  [NUM_SLOTS];
  logic              res_ready [NUM_SLOTS];
  logic              iss_en    [NUM_SLOTS];
  logic [REG_AW-1:0] iss_rd    [NUM_SLOTS];
  wb_entry_t         entry     [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] eligible;
  logic [NUM_SLOTS-1:0] lose;
  logic [NUM_SLOTS-1:0] commit;
  logic [2:0]           lose_cnt;
  logic [NUM_REGS-1:0]  set_vec;
  logic [NUM_REGS-1:0]  clr_vec;
  logic [CNT_W:0]       cnt_sum;

  assign res_valid[SLOT_LSU]    = lsu_res_valid;
  assign res_rd[SLOT_LSU]       = lsu_res_rd;
  assign res_data[SLOT_LSU]     = lsu_res_data;
  assign iss_en[SLOT_LSU]       = lsu_iss_en;
  assign iss_rd[SLOT_LSU]       = lsu_iss_rd;
  assign res_valid[SLOT_IXU1]   = ixu1_res_valid;
  assign res_rd[SLOT_IXU1]      = ixu1_res_rd;
  assign res_data[SLOT_IXU1]    = ixu1_res_data;
  assign iss_en[SLOT_IXU1]      = ixu1_iss_en;
  assign iss_rd[SLOT_IXU1]      = ixu1_iss_rd;
  assign res_valid[SLOT_IXU2]   = ixu2_res_valid;
  assign res_rd[SLOT_IXU2]      = ixu2_res_rd;
  assign res_data[SLOT_IXU2]    = ixu2_res_data;
  assign iss_en[SLOT_IXU2]      = ixu2_iss_en;
  assign iss_rd[SLOT_IXU2]      = ixu2_iss_rd;
  assign res_valid[SLOT_BRANCH] = branch_res_valid;
  assign res_rd[SLOT_BRANCH]    = branch_res_rd;
  assign res_data[SLOT_BRANCH]  = branch_res_data;
  assign iss_en[SLOT_BRANCH]    = branch_iss_en;
  assign iss_rd[SLOT_BRANCH]    = branch_iss_rd;

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    wb_slot_buffer u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .res_valid (res_valid[s]),
      .res_rd    (res_rd[s]),
      .res_data  (res_data[s]),
      .res_ready (res_ready[s]),
      .commit    (commit[s]),
      .entry     (entry[s])
    );
  end

  // A slot loses when any higher-priority eligible slot targets the same rd.
  always_comb begin
    eligible = '0;
    lose     = '0;
    lose_cnt = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      eligible[s] = entry[s].valid && (entry[s].rd != '0);
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      for (int t = 0; t < NUM_SLOTS; t++) begin
        if (eligible[s] && eligible[t] && (entry[s].rd == entry[t].rd) &&
            outranks(slot_e'(2'(t)), slot_e'(2'(s)))) begin
          lose[s] = 1'b1;
        end
      end
      lose_cnt = lose_cnt + 3'(lose[s]);
    end
    commit = eligible & ~lose;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (iss_en[s]) set_vec[iss_rd[s]] = 1'b1;
      if (commit[s]) clr_vec[entry[s].rd] = 1'b1;
    end
    set_vec[0] = 1'b0;
  end

  assign cnt_sum = {1'b0, collision_cnt} + (CNT_W+1)'(lose_cnt);

  // Set wins over clear so a re-issued destination stays outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_mask  <= '0;
      collision_cnt <= '0;
    end else begin
      pending_mask  <= ((pending_mask & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
      collision_cnt <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end
  end

  assign lsu_res_ready    = res_ready[SLOT_LSU];
  assign lsu_wr_en        = commit[SLOT_LSU];
  assign lsu_rd           = entry[SLOT_LSU].rd;
  assign lsu_wr_data      = entry[SLOT_LSU].data;
  assign ixu1_res_ready   = res_ready[SLOT_IXU1];
  assign ixu1_wr_en       = commit[SLOT_IXU1];
  assign ixu1_rd          = entry[SLOT_IXU1].rd;
  assign ixu1_wr_data     = entry[SLOT_IXU1].data;
  assign ixu2_res_ready   = res_ready[SLOT_IXU2];
  assign ixu2_wr_en       = commit[SLOT_IXU2];
  assign ixu2_rd          = entry[SLOT_IXU2].rd;
  assign ixu2_wr_data     = entry[SLOT_IXU2].data;
  assign branch_res_ready = res_ready[SLOT_BRANCH];
  assign branch_wr_en     = commit[SLOT_BRANCH];
  assign branch_rd        = entry[SLOT_BRANCH].rd;
  assign branch_wr_data   = entry[SLOT_BRANCH].data;

`ifndef SYNTHESIS
  // Two slots issuing to the same nonzero rd in one cycle is an issue-stage bug.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int a = 0; a < NUM_SLOTS; a++) begin
        for (int b = a + 1; b < NUM_SLOTS; b++) begin
          assert (!(iss_en[a] && iss_en[b] && iss_rd[a] == iss_rd[b] && iss_rd[a] != '0))
            else $error("duplicate issue to x%0d", iss_rd[a]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
module tb_writeback_stage;
  import vliw_pkg::*;

  logic clk;
  logic rst_n;

  logic              lsu_res_valid, ixu1_res_valid, ixu2_res_valid, branch_res_valid;
  logic [REG_AW-1:0] lsu_res_rd, ixu1_res_rd, ixu2_res_rd, branch_res_rd;
  logic [XLEN-1:0]   lsu_res_data, ixu1_res_data, ixu2_res_data, branch_res_data;
  logic              lsu_res_ready, ixu1_res_ready, ixu2_res_ready, branch_res_ready;
  logic              lsu_wr_en, ixu1_wr_en, ixu2_wr_en, branch_wr_en;
  logic [REG_AW-1:0] lsu_rd, ixu1_rd, ixu2_rd, branch_rd;
  logic [XLEN-1:0]   lsu_wr_data, ixu1_wr_data, ixu2_wr_data, branch_wr_data;
  logic              lsu_iss_en, ixu1_iss_en, ixu2_iss_en, branch_iss_en;
  logic [REG_AW-1:0] lsu_iss_rd, ixu1_iss_rd, ixu2_iss_rd, branch_iss_rd;
  logic [NUM_REGS-1:0] pending_mask;
  logic [CNT_W-1:0]    collision_cnt;

  int checks;
  int errors;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_res_valid(lsu_res_valid), .lsu_res_rd(lsu_res_rd), .lsu_res_data(lsu_res_data),
    .lsu_res_ready(lsu_res_ready), .lsu_wr_en(lsu_wr_en), .lsu_rd(lsu_rd),
    .lsu_wr_data(lsu_wr_data), .lsu_iss_en(lsu_iss_en), .lsu_iss_rd(lsu_iss_rd),
    .ixu1_res_valid(ixu1_res_valid), .ixu1_res_rd(ixu1_res_rd), .ixu1_res_data(ixu1_res_data),
    .ixu1_res_ready(ixu1_res_ready), .ixu1_wr_en(ixu1_wr_en), .ixu1_rd(ixu1_rd),
    .ixu1_wr_data(ixu1_wr_data), .ixu1_iss_en(ixu1_iss_en), .ixu1_iss_rd(ixu1_iss_rd),
    .ixu2_res_valid(ixu2_res_valid), .ixu2_res_rd(ixu2_res_rd), .ixu2_res_data(ixu2_res_data),
    .ixu2_res_ready(ixu2_res_ready), .ixu2_wr_en(ixu2_wr_en), .ixu2_rd(ixu2_rd),
    .ixu2_wr_data(ixu2_wr_data), .ixu2_iss_en(ixu2_iss_en), .ixu2_iss_rd(ixu2_iss_rd),
    .branch_res_valid(branch_res_valid), .branch_res_rd(branch_res_rd),
    .branch_res_data(branch_res_data), .branch_res_ready(branch_res_ready),
    .branch_wr_en(branch_wr_en), .branch_rd(branch_rd), .branch_wr_data(branch_wr_data),
    .branch_iss_en(branch_iss_en), .branch_iss_rd(branch_iss_rd),
    .pending_mask(pending_mask), .collision_cnt(collision_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lsu_res_valid = 0; ixu1_res_valid = 0; ixu2_res_valid = 0; branch_res_valid = 0;
    lsu_res_rd = 0; ixu1_res_rd = 0; ixu2_res_rd = 0; branch_res_rd = 0;
    lsu_res_data = 0; ixu1_res_data = 0; ixu2_res_data = 0; branch_res_data = 0;
    lsu_iss_en = 0; ixu1_iss_en = 0; ixu2_iss_en = 0; branch_iss_en = 0;
    lsu_iss_rd = 0; ixu1_iss_rd = 0; ixu2_iss_rd = 0; branch_iss_rd = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    lsu_res_valid = 1; ixu1_res_valid = 1; ixu2_res_valid = 1; branch_res_valid = 1;
    lsu_res_rd = 1; ixu1_res_rd = 2; ixu2_res_rd = 3; branch_res_rd = 4;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({lsu_wr_en, ixu1_wr_en, ixu2_wr_en, branch_wr_en} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_wr_en got %b exp 0000",
                 {lsu_wr_en, ixu1_wr_en, ixu2_wr_en, branch_wr_en});
      end
    end
    checks++;
    if (pending_mask !== '0 || collision_cnt !== '0 || lsu_rd !== '0 || branch_wr_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state got mask %h cnt %h exp 0 0", pending_mask, collision_cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({lsu_res_ready, ixu1_res_ready, ixu2_res_ready, branch_res_ready} !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b exp 1111",
               {lsu_res_ready, ixu1_res_ready, ixu2_res_ready, branch_res_ready});
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_single_write();
    ixu1_iss_en = 1; ixu1_iss_rd = 5;
    tick();
    ixu1_iss_en = 0;
    checks++;
    if (pending_mask !== 32'h0000_0020) begin
      errors++;
      $display("[TB] FAIL single_pending_set got %h exp 00000020", pending_mask);
    end
    ixu1_res_valid = 1; ixu1_res_rd = 5; ixu1_res_data = 32'hDEADBEEF;
    tick();
    ixu1_res_valid = 0;
    checks++;
    if (ixu1_wr_en !== 1'b1 || ixu1_rd !== 5'd5 || ixu1_wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL single_write got en %b rd %0d data %h exp 1 5 deadbeef",
               ixu1_wr_en, ixu1_rd, ixu1_wr_data);
    end
    tick();
    checks++;
    if (pending_mask !== '0 || ixu1_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_clear got mask %h en %b exp 0 0", pending_mask, ixu1_wr_en);
    end
  endtask

  task automatic test_collision();
    lsu_res_valid = 1; lsu_res_rd = 7; lsu_res_data = 32'hAAAA0001;
    branch_res_valid = 1; branch_res_rd = 7; branch_res_data = 32'hBBBB0002;
    tick();
    lsu_res_valid = 0; branch_res_valid = 0;
    checks++;
    if (branch_wr_en !== 1'b1 || branch_wr_data !== 32'hBBBB0002 || lsu_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL coll_winner got br %b %h lsu %b exp 1 bbbb0002 0",
               branch_wr_en, branch_wr_data, lsu_wr_en);
    end
    checks++;
    if (lsu_res_ready !== 1'b0 || collision_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL coll_hold got ready %b cnt %0d exp 0 0", lsu_res_ready, collision_cnt);
    end
    tick();
    checks++;
    if (lsu_wr_en !== 1'b1 || lsu_wr_data !== 32'hAAAA0001 || branch_wr_en !== 1'b0 ||
        lsu_res_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL coll_loser got lsu %b %h br %b ready %b exp 1 aaaa0001 0 1",
               lsu_wr_en, lsu_wr_data, branch_wr_en, lsu_res_ready);
    end
    checks++;
    if (collision_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL coll_cnt got %0d exp 1", collision_cnt);
    end
    tick();
  endtask

  task automatic test_x0_discard();
    ixu2_res_valid = 1; ixu2_res_rd = 0; ixu2_res_data = 32'h1234;
    tick();
    ixu2_res_valid = 0;
    checks++;
    if (ixu2_wr_en !== 1'b0 || ixu2_res_ready !== 1'b1 || ixu2_wr_data !== 32'h1234) begin
      errors++;
      $display("[TB] FAIL x0_hold got en %b ready %b data %h exp 0 1 1234",
               ixu2_wr_en, ixu2_res_ready, ixu2_wr_data);
    end
    tick();
    checks++;
    if (ixu2_wr_en !== 1'b0 || pending_mask !== '0) begin
      errors++;
      $display("[TB] FAIL x0_after got en %b mask %h exp 0 0", ixu2_wr_en, pending_mask);
    end
  endtask

  task automatic test_scoreboard_race();
    branch_iss_en = 1; branch_iss_rd = 9;
    tick();
    branch_iss_en = 0;
    branch_res_valid = 1; branch_res_rd = 9; branch_res_data = 32'h99;
    tick();
    branch_res_valid = 0;
    ixu1_iss_en = 1; ixu1_iss_rd = 9;
    checks++;
    if (branch_wr_en !== 1'b1 || pending_mask !== 32'h0000_0200) begin
      errors++;
      $display("[TB] FAIL race_pre got en %b mask %h exp 1 00000200", branch_wr_en, pending_mask);
    end
    tick();
    ixu1_iss_en = 0;
    checks++;
    if (pending_mask !== 32'h0000_0200) begin
      errors++;
      $display("[TB] FAIL race_keep got %h exp 00000200", pending_mask);
    end
    // Retire the re-issued op so later tests start with an empty scoreboard.
    ixu1_res_valid = 1; ixu1_res_rd = 9; ixu1_res_data = 32'h1;
    tick();
    ixu1_res_valid = 0;
    tick();
    checks++;
    if (pending_mask !== '0) begin
      errors++;
      $display("[TB] FAIL race_drain got %h exp 0", pending_mask);
    end
  endtask

  task automatic test_back_to_back();
    logic [REG_AW-1:0] base;
    for (int i = 0; i < 100; i++) begin
      base = REG_AW'(1 + (i % 7) * 4);
      lsu_res_valid = 1; ixu1_res_valid = 1; ixu2_res_valid = 1; branch_res_valid = 1;
      lsu_res_rd = base; ixu1_res_rd = base + 1; ixu2_res_rd = base + 2; branch_res_rd = base + 3;
      lsu_res_data = 32'h1000_0000 + i; ixu1_res_data = 32'h2000_0000 + i;
      ixu2_res_data = 32'h3000_0000 + i; branch_res_data = 32'h4000_0000 + i;
      #1;
      checks++;
      if ({lsu_res_ready, ixu1_res_ready, ixu2_res_ready, branch_res_ready} !== 4'b1111) begin
        errors++;
        $display("[TB] FAIL stream_ready[%0d] got %b exp 1111", i,
                 {lsu_res_ready, ixu1_res_ready, ixu2_res_ready, branch_res_ready});
      end
      tick();
      checks++;
      if ({lsu_wr_en, ixu1_wr_en, ixu2_wr_en, branch_wr_en} !== 4'b1111 ||
          lsu_wr_data !== 32'h1000_0000 + i || ixu1_wr_data !== 32'h2000_0000 + i ||
          ixu2_wr_data !== 32'h3000_0000 + i || branch_wr_data !== 32'h4000_0000 + i ||
          branch_rd !== base + 3) begin
        errors++;
        $display("[TB] FAIL stream_write[%0d] got en %b lsu %h br %h exp 1111 %h %h", i,
                 {lsu_wr_en, ixu1_wr_en, ixu2_wr_en, branch_wr_en}, lsu_wr_data,
                 branch_wr_data, 32'h1000_0000 + i, 32'h4000_0000 + i);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (collision_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL stream_cnt got %0d exp 1", collision_cnt);
    end
  endtask

  task automatic test_saturation();
    lsu_res_valid = 1; ixu1_res_valid = 1; ixu2_res_valid = 1; branch_res_valid = 1;
    lsu_res_rd = 1; ixu1_res_rd = 1; ixu2_res_rd = 1; branch_res_rd = 1;
    repeat (10) tick();
    checks++;
    if (collision_cnt !== 16'd28) begin
      errors++;
      $display("[TB] FAIL sat_rate got %0d exp 28", collision_cnt);
    end
    repeat (22000) tick();
    idle_inputs();
    repeat (5) tick();
    checks++;
    if (collision_cnt !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL sat_hold got %h exp ffff", collision_cnt);
    end
  endtask

  task automatic test_midop_reset();
    ixu2_iss_en = 1; ixu2_iss_rd = 4;
    lsu_res_valid = 1; lsu_res_rd = 3; lsu_res_data = 32'h33;
    branch_res_valid = 1; branch_res_rd = 3; branch_res_data = 32'h44;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lsu_wr_en, ixu1_wr_en, ixu2_wr_en, branch_wr_en} !== 4'b0000 ||
        pending_mask !== '0 || collision_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL midreset got en %b mask %h cnt %h exp 0 0 0",
               {lsu_wr_en, ixu1_wr_en, ixu2_wr_en, branch_wr_en}, pending_mask, collision_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (lsu_wr_en !== 1'b0 || lsu_rd !== '0 || lsu_wr_data !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_discard got en %b rd %0d data %h exp 0 0 0",
               lsu_wr_en, lsu_rd, lsu_wr_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_write();
    test_collision();
    test_x0_discard();
    test_scoreboard_race();
    test_back_to_back();
    test_saturation();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
